// File: rtl/run_counter_p2.sv
// Tracks runs of identical bits on w and flags the Nth consecutive equal bit
// combinationally (c), with a registered one-cycle detect pulse (z).
module run_counter_p2 #(
    parameter int unsigned N  = 4,
    parameter int unsigned CW = 3
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          en,
    input  logic          w,
    input  logic [2:0]    state,
    output logic          c,
    output logic [CW-1:0] count,
    output logic          z
);

    typedef enum logic [2:0] {
        S0 = 3'b000,
        S1 = 3'b001,
        S2 = 3'b010,
        S3 = 3'b011,
        S4 = 3'b100
    } state_e;

    localparam logic [CW-1:0] CNT_MAX = CW'(N);
    localparam logic [CW-1:0] CNT_PRE = CW'(N - 1);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    logic [CW-1:0] count_q, count_d;
    logic          prev_w_q, prev_w_d;
    logic          z_q, z_d;
    logic          same_bit;
    logic          state_match;

    assign same_bit    = (w == prev_w_q);
    assign state_match = ((state == S1) && !w) || ((state == S3) && w);

    always_comb begin
        count_d  = count_q;
        prev_w_d = prev_w_q;
        z_d      = z_q;
        c        = 1'b0;
        if (en && !reset) begin
            c = (count_q == CNT_PRE) && same_bit && state_match;
        end
        if (en) begin
            prev_w_d = w;
            z_d      = c;
            // count_q==0 only right after reset, so it always starts a fresh run
            if ((count_q != '0) && same_bit) begin
                count_d = (count_q == CNT_MAX) ? CNT_MAX : count_q + CNT_ONE;
            end else begin
                count_d = CNT_ONE;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q  <= '0;
            prev_w_q <= 1'b0;
            z_q      <= 1'b0;
        end else begin
            count_q  <= count_d;
            prev_w_q <= prev_w_d;
            z_q      <= z_d;
        end
    end

    assign count = count_q;
    assign z     = z_q;

endmodule

// File: tb/tb_run_counter_p2.sv
// Bench for run_counter_p2: history-based model checked every cycle, plus
// hand-computed directed vectors.
module tb_run_counter_p2;

    localparam int N  = 4;
    localparam int CW = 3;
    localparam logic [2:0] S0 = 3'd0;
    localparam logic [2:0] S1 = 3'd1;
    localparam logic [2:0] S3 = 3'd3;

    logic          clk   = 1'b0;
    logic          reset = 1'b1;
    logic          en    = 1'b0;
    logic          w     = 1'b0;
    logic [2:0]    state = 3'd0;
    logic          c;
    logic [CW-1:0] count;
    logic          z;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    run_counter_p2 #(.N(N), .CW(CW)) dut (
        .clk   (clk),
        .reset (reset),
        .en    (en),
        .w     (w),
        .state (state),
        .c     (c),
        .count (count),
        .z     (z)
    );

    // Model: the accepted sample history since reset; run length is the
    // number of trailing identical bits, capped at N.
    bit   hist[$];
    logic mz = 1'b0;

    function automatic int run_len();
        int n;
        int last;
        if (hist.size() == 0) return 0;
        last = hist.size() - 1;
        n = 1;
        for (int i = last - 1; i >= 0; i--) begin
            if (n >= N) break;
            if (hist[i] == hist[last]) n++;
            else break;
        end
        return n;
    endfunction

    function automatic logic model_c();
        if (!en || reset || hist.size() == 0) return 1'b0;
        if (run_len() != N - 1) return 1'b0;
        if (w != hist[hist.size() - 1]) return 1'b0;
        return ((state == S1) && !w) || ((state == S3) && w);
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            hist.delete();
            mz <= 1'b0;
        end else if (en) begin
            mz <= model_c();
            hist.push_back(w);
            if (hist.size() > 8) void'(hist.pop_front());
        end
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            check("model_count", 32'(count), 32'(run_len()));
            check("model_c", 32'(c), 32'(model_c()));
            check("model_z", 32'(z), 32'(mz));
        end
    end

    // One cycle: drive after the edge, check literals mid-cycle (-1 = skip).
    task automatic step(input logic e, input logic wb, input logic [2:0] st,
                        input int ec, input int ecc, input int ez);
        @(posedge clk);
        #1;
        en    = e;
        w     = wb;
        state = st;
        @(negedge clk);
        if (ec >= 0)  check("vec_count", 32'(count), 32'(ec));
        if (ecc >= 0) check("vec_c", 32'(c), 32'(ecc));
        if (ez >= 0)  check("vec_z", 32'(z), 32'(ez));
    endtask

    // Reset pulse between edges; state must clear without a clock edge.
    task automatic pulse();
        @(posedge clk);
        #1;
        en    = 1'b0;
        reset = 1'b1;
        #1;
        check("rst_count", 32'(count), 32'd0);
        check("rst_c", 32'(c), 32'd0);
        check("rst_z", 32'(z), 32'd0);
        #1;
        reset = 1'b0;
    endtask

    logic [2:0] bad_st [8] = '{3'd5, 3'd2, 3'd4, 3'd1, 3'd3, 3'd0, 3'd7, 3'd6};
    logic       bad_w  [8] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};

    initial begin
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        // Four zeros from reset; the following pulse sees z just set
        step(1, 0, S0, 0, 0, 0);
        step(1, 0, S1, 1, 0, 0);
        step(1, 0, S1, 2, 0, 0);
        step(1, 0, S1, 3, 1, 0);
        pulse();

        // Restart on every bit change
        step(1, 1, S0, 0, 0, 0);
        step(1, 1, S3, 1, 0, 0);
        step(1, 0, S3, 2, 0, 0);
        step(1, 1, S1, 1, 0, 0);
        step(1, 1, S3, 1, 0, 0);
        step(1, 1, S3, 2, 0, 0);
        step(1, 1, S3, 3, 1, 0);
        step(1, 1, S3, 4, 0, 1);
        pulse();

        // Seven zeros: saturation, single detect, single z pulse
        step(1, 0, S1, 0, 0, 0);
        step(1, 0, S1, 1, 0, 0);
        step(1, 0, S1, 2, 0, 0);
        step(1, 0, S1, 3, 1, 0);
        step(1, 0, S1, 4, 0, 1);
        step(1, 0, S1, 4, 0, 0);
        step(1, 0, S1, 4, 0, 0);
        step(1, 0, S1, 4, 0, 0);
        pulse();

        // Enable gaps: hold count, force c low, hold z high
        step(1, 0, S1, 0, 0, 0);
        step(1, 0, S1, 1, 0, 0);
        step(1, 0, S1, 2, 0, 0);
        step(0, 0, S1, 3, 0, 0);
        step(0, 0, S1, 3, 0, 0);
        step(1, 0, S1, 3, 1, 0);
        step(0, 0, S1, 4, 0, 1);
        step(0, 0, S1, 4, 0, 1);
        step(1, 0, S1, 4, 0, 1);
        step(1, 0, S1, 4, 0, 0);
        pulse();

        // Reset mid-run discards the partial run
        step(1, 1, S3, 0, 0, 0);
        step(1, 1, S3, 1, 0, 0);
        pulse();
        step(1, 1, S3, 0, 0, 0);
        step(1, 1, S3, 1, 0, 0);
        step(1, 1, S3, 2, 0, 0);
        step(1, 1, S3, 3, 1, 0);
        step(1, 1, S3, 4, 0, 1);

        // count==N-1 with matching bit but a non-detecting state or polarity
        for (int k = 0; k < 8; k++) begin
            pulse();
            step(1, bad_w[k], S0, 0, 0, 0);
            step(1, bad_w[k], S0, 1, 0, 0);
            step(1, bad_w[k], S0, 2, 0, 0);
            step(1, bad_w[k], bad_st[k], 3, 0, 0);
        end

        @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/run_counter_p2.md
RUN_COUNTER_P2 -- requirements
Module: run_counter_P2

Interface
REQ-001 Parameter N, default 4: run length to detect; legal range 2..(2^CW - 1).
REQ-002 Parameter CW, default 3: counter width in bits.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 en  input  1  sample enable; when 0 the block holds and c is forced 0.
REQ-006 w  input  1  serial data bit under test.
REQ-007 state  input  3  current FSM state: S0=000 start, S1=001 counting zeros, S2=010 N zeros seen, S3=011 counting ones, S4=100 N ones seen; codes 101..111 illegal.
REQ-008 c  output  1  count-done flag to the next-state logic, combinational.
REQ-009 count  output  CW  current run length, registered.
REQ-010 z  output  1  registered detect pulse.

Function
REQ-011 The block SHALL hold registers prev_w (1 bit), count (CW bits) and z (1 bit).
REQ-012 Run tracking on a clock edge with en=1: if count!=0 and w==prev_w, count <= min(count+1, N); otherwise count <= 1. prev_w <= w in both cases.
REQ-013 Count SHALL saturate at N, never wrap, and remain at N while the run continues.
REQ-014 With en=0, count, prev_w and z SHALL hold their values; c SHALL be 0.
REQ-015 c SHALL be 1 iff en=1 and count==N-1 and w==prev_w and either (state==S1 and w==0) or (state==S3 and w==1).
REQ-016 c SHALL be asserted in the same cycle the Nth consecutive equal bit is presented on w, with zero latency.
REQ-017 c SHALL be 0 in S0, S2, S4 and in illegal state codes, regardless of count.
REQ-018 A bit change (w!=prev_w) SHALL restart the run: count becomes 1 at the next edge, and c is 0 in the change cycle.
REQ-019 After saturation (count==N), further equal bits SHALL NOT re-assert c; a fresh run of N bits is required.
REQ-020 z SHALL be set to 1 on the edge where c==1, and cleared on the next edge with en=1; z is a one-cycle pulse per detection.
REQ-021 Simultaneous c==1 and en deassertion cannot occur: c requires en=1. An en=0 cycle after c leaves z held high until en returns.
REQ-022 The first sample after reset SHALL be treated as a new run (count==0 forces load of 1).

Reset
REQ-023 reset=1 SHALL immediately, without waiting for clk, force count=0, prev_w=0 and z=0; c SHALL read 0 while reset is high.
REQ-024 Reset asserted mid-run SHALL discard the partial run; the first sample after release starts at count=1.
REQ-025 Reset release SHALL take effect on the first rising clk edge at which reset is low.

Verification (N=4, CW=3, en=1 unless stated)
REQ-026 Reset, then w=0,0,0,0 with state S0,S1,S1,S1: count reads 0,1,2,3; c=1 only in the 4th cycle; z=1 in the following cycle only.
REQ-027 w=1,1,0,1,1,1,1 with state S0,S3,S3,S1,S3,S3,S3: c=0 through the 6th cycle; count restarts at 1 after each change; c=1 on the 7th bit.
REQ-028 Seven consecutive zeros in state S1: c=1 only at the 4th; count holds at 4 from the 5th cycle onward; no further c.
REQ-029 Three zeros, then en=0 for 2 cycles, then one zero: count holds at 3 during en=0 with c=0; c=1 on the resumed zero.
REQ-030 Two ones, then async reset pulse between edges, then ones: count=0 and z=0 immediately; c first asserts on the 4th post-reset one.
REQ-031 count==3, w matching, state=101 or S2: c=0.
